// File: rtl/serial_subtractor.sv
// serial_subtractor
//   Bit-serial unsigned subtractor: diff = (a - b - bin) mod 2^WIDTH.
//   The operands are handled one bit per clock, LSB first, through a single
//   borrow flip-flop. A start/busy/done handshake frames each operation, and
//   the result stays registered until the next operation completes.
//
// Ports
//   clock  in   rising-edge clock
//   reset  in   synchronous, active-high reset
//   start  in   operation request, sampled only in IDLE
//   a      in   minuend   [WIDTH-1:0], sampled on the accepting edge
//   b      in   subtrahend[WIDTH-1:0], sampled on the accepting edge
//   bin    in   borrow-in, sampled on the accepting edge
//   busy   out  high while bits are being processed (state == CALC)
//   done   out  one-cycle pulse when the result is valid (state == DONE)
//   diff   out  registered difference [WIDTH-1:0]
//   bout   out  registered borrow-out
//   zero   out  registered, 1 iff diff == 0
//
// Legal WIDTH range: 2..16.

module serial_subtractor #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             zero
);

  // Counter indexes bits 0..WIDTH-1 and never needs to wrap.
  localparam int unsigned CNT_W  = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  // Working register holds the WIDTH-1 lower result bits; the top bit is
  // merged in on the final cycle, so nothing ever falls off the end.
  localparam int unsigned WORK_W = WIDTH - 1;

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]        state_q,  state_d;
  logic [WIDTH-1:0]  a_q,      a_d;
  logic [WIDTH-1:0]  b_q,      b_d;
  logic              borrow_q, borrow_d;
  logic [CNT_W-1:0]  cnt_q,    cnt_d;
  logic [WORK_W-1:0] work_q,   work_d;
  logic [WIDTH-1:0]  diff_q,   diff_d;
  logic              bout_q,   bout_d;
  logic              zero_q,   zero_d;

  logic              diff_bit;
  logic              borrow_nxt;
  logic [WIDTH-1:0]  result_full;

  // One-bit full subtractor on the current LSBs.
  always_comb begin
    diff_bit   = a_q[0] ^ b_q[0] ^ borrow_q;
    borrow_nxt = (~a_q[0] & b_q[0]) | (~a_q[0] & borrow_q) | (b_q[0] & borrow_q);
  end

  // Completed result as it stands once the current bit is included.
  assign result_full = {diff_bit, work_q};

  // State and datapath registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
      work_q   <= '0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      borrow_q <= borrow_d;
      cnt_q    <= cnt_d;
      work_q   <= work_d;
      diff_q   <= diff_d;
      bout_q   <= bout_d;
      zero_q   <= zero_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    borrow_d = borrow_q;
    cnt_d    = cnt_q;
    work_d   = work_q;
    diff_d   = diff_q;
    bout_d   = bout_q;
    zero_d   = zero_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_d      = a;
          b_d      = b;
          borrow_d = bin;
          cnt_d    = '0;
          state_d  = ST_CALC;
        end
      end

      ST_CALC: begin
        a_d      = {1'b0, a_q[WIDTH-1:1]};
        b_d      = {1'b0, b_q[WIDTH-1:1]};
        borrow_d = borrow_nxt;
        // Shift the new bit in at the top of the working register.
        work_d   = (work_q >> 1) | (WORK_W'(diff_bit) << (WORK_W - 1));
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_BIT) begin
          diff_d  = result_full;
          bout_d  = borrow_nxt;
          zero_d  = (result_full == '0);
          cnt_d   = '0;
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Handshake decoded straight from the state register.
  assign busy = (state_q == ST_CALC);
  assign done = (state_q == ST_DONE);

  assign diff = diff_q;
  assign bout = bout_q;
  assign zero = zero_q;

endmodule
